reset_request_responder: RTL



---
 rtl/reset_request_responder_pkg.sv | 11 +
 rtl/reset_request_responder_delay_counter.sv | 28 ++
 rtl/reset_request_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reset_request_responder_pkg.sv
// Shared types and helpers for the reset request/acknowledge responder.
package reset_pkg;

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT, ACK} rrr_state_t;

  // Counter width for a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_request_responder_delay_counter.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module delay_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= WIDTH'(RESET_VAL);
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/reset_request_responder.sv
// Drives a minimum-length reset pulse downstream, waits for done (or a timeout),
// then acknowledges the requester with a 4-phase handshake. Power-up runs the same pulse unacknowledged.
module reset_request_responder
  import reset_pkg::*;
#(
  parameter int LENGTH  = 16,
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic ack_o,
  output logic rst_o,
  input  logic done_i,
  output logic timeout_o,
  output logic busy_o
);

  localparam int RCNT_W = cnt_width(LENGTH);

  rrr_state_t state_reg;
  logic       rst_reg;
  logic       ack_reg;
  logic       timeout_reg;
  logic       pending_reg;
  logic       rcnt_load;
  logic       rcnt_dec;
  logic       rcnt_zero;
  logic       timeout_hit;

  assign rcnt_load = (state_reg == IDLE) && req_i;
  assign rcnt_dec  = (state_reg == ASSERT);

  delay_counter #(
    .WIDTH    (RCNT_W),
    .RESET_VAL(LENGTH - 1)
  ) u_rcnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (rcnt_load),
    .load_val(RCNT_W'(LENGTH - 1)),
    .dec     (rcnt_dec),
    .zero    (rcnt_zero)
  );

  // With TIMEOUT == 0 the wait is unbounded and no timeout counter exists.
  generate
    if (TIMEOUT != 0) begin : g_tcnt
      localparam int TCNT_W = cnt_width(TIMEOUT + 1);
      logic [TCNT_W-1:0] tcnt_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          tcnt_reg <= '0;
        end else if (state_reg == ASSERT) begin
          tcnt_reg <= '0;
        end else if ((state_reg == WAIT) && !done_i && !timeout_hit) begin
          tcnt_reg <= tcnt_reg + TCNT_W'(1);
        end
      end

      assign timeout_hit = (tcnt_reg == TCNT_W'(TIMEOUT - 1));
    end else begin : g_no_tcnt
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= ASSERT;
      rst_reg     <= 1'b1;
      ack_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req_i) begin
            state_reg   <= ASSERT;
            rst_reg     <= 1'b1;
            pending_reg <= 1'b1;
            timeout_reg <= 1'b0;
          end
        end
        ASSERT: begin
          if (rcnt_zero) begin
            state_reg <= WAIT;
            rst_reg   <= 1'b0;
          end
        end
        WAIT: begin
          // done_i wins over a timeout expiring on the same edge.
          if (done_i || timeout_hit) begin
            if (!done_i) begin
              timeout_reg <= 1'b1;
            end
            if (pending_reg) begin
              state_reg <= ACK;
              ack_reg   <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        ACK: begin
          if (!req_i) begin
            state_reg   <= IDLE;
            ack_reg     <= 1'b0;
            pending_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rst_o     = rst_reg;
  assign ack_o     = ack_reg;
  assign timeout_o = timeout_reg;
  assign busy_o    = (state_reg != IDLE);

endmodule
